// File: rtl/clk_div_ctrl.sv
// Reconfiguration sequencer for a clk_divider: accepts (ratio, enable) requests,
// waits for the divided clock to fall, gates the divider, loads, re-enables, then reports lock.
module clk_div_ctrl #(
    parameter int WIDTH         = 5,
    parameter int MIN_RATIO     = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int TIMEOUT       = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_ratio,
    input  logic             cfg_enable,
    output logic             cfg_err,
    input  logic             div_clk_in,
    output logic [WIDTH-1:0] div_ratio_out,
    output logic             div_en_out,
    output logic             busy,
    output logic             locked
);

    // One counter serves both the edge-wait timeout and the settle delay.
    localparam int CNT_MAX = (TIMEOUT > SETTLE_CYCLES) ? TIMEOUT : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] MIN_RATIO_W  = WIDTH'(MIN_RATIO);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_EDGE,
        ST_GATE,
        ST_LOAD,
        ST_SETTLE
    } state_t;

    state_t             state_reg, state_next;
    logic               div_en_reg, div_en_next;
    logic [WIDTH-1:0]   div_ratio_reg, div_ratio_next;
    logic [WIDTH-1:0]   hold_ratio_reg, hold_ratio_next;
    logic               hold_en_reg, hold_en_next;
    logic               cfg_err_reg, cfg_err_next;
    logic               locked_reg, locked_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               edge_reg;

    logic               cfg_xfer;
    logic               req_illegal;
    logic               req_same;
    logic               edge_fall;
    logic [WIDTH-1:0]   ratio_bit_match;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_ratio_match
            assign ratio_bit_match[gi] = ~(cfg_ratio[gi] ^ div_ratio_reg[gi]);
        end
    endgenerate

    assign cfg_ready   = (state_reg == ST_IDLE) & ~reset;
    assign busy        = (state_reg != ST_IDLE);
    assign cfg_xfer    = cfg_valid & cfg_ready;
    assign req_illegal = cfg_enable & (cfg_ratio < MIN_RATIO_W);
    assign req_same    = (&ratio_bit_match) & (cfg_enable == div_en_reg);
    assign edge_fall   = edge_reg & ~div_clk_in;

    assign div_ratio_out = div_ratio_reg;
    assign div_en_out    = div_en_reg;
    assign cfg_err       = cfg_err_reg;
    assign locked        = locked_reg;

    always_comb begin
        state_next      = state_reg;
        div_en_next     = div_en_reg;
        div_ratio_next  = div_ratio_reg;
        hold_ratio_next = hold_ratio_reg;
        hold_en_next    = hold_en_reg;
        locked_next     = locked_reg;
        cnt_next        = cnt_reg;
        cfg_err_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (cfg_xfer) begin
                    hold_ratio_next = cfg_ratio;
                    hold_en_next    = cfg_enable;
                    if (req_illegal) begin
                        cfg_err_next = 1'b1;
                    end else if (!req_same) begin
                        // A stopped divider has no edge to wait for.
                        if (!div_en_reg) begin
                            state_next = ST_LOAD;
                        end else begin
                            state_next  = ST_WAIT_EDGE;
                            locked_next = 1'b0;
                            cnt_next    = '0;
                        end
                    end
                end
            end

            ST_WAIT_EDGE: begin
                if (edge_fall || (cnt_reg == TIMEOUT_LAST)) begin
                    state_next = ST_GATE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_GATE: begin
                div_en_next = 1'b0;
                state_next  = ST_LOAD;
            end

            ST_LOAD: begin
                div_ratio_next = hold_ratio_reg;
                div_en_next    = hold_en_reg;
                locked_next    = 1'b0;
                if (hold_en_reg) begin
                    state_next = ST_SETTLE;
                    cnt_next   = '0;
                end else begin
                    state_next = ST_IDLE;
                end
            end

            ST_SETTLE: begin
                if (cnt_reg == SETTLE_LAST) begin
                    state_next  = ST_IDLE;
                    locked_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            div_en_reg     <= 1'b0;
            div_ratio_reg  <= MIN_RATIO_W;
            hold_ratio_reg <= MIN_RATIO_W;
            hold_en_reg    <= 1'b0;
            cfg_err_reg    <= 1'b0;
            locked_reg     <= 1'b0;
            cnt_reg        <= '0;
            edge_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            div_en_reg     <= div_en_next;
            div_ratio_reg  <= div_ratio_next;
            hold_ratio_reg <= hold_ratio_next;
            hold_en_reg    <= hold_en_next;
            cfg_err_reg    <= cfg_err_next;
            locked_reg     <= locked_next;
            cnt_reg        <= cnt_next;
            edge_reg       <= div_clk_in;
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized bench for clk_div_ctrl, checked per request against a transaction-level model
// that predicts busy duration, gate timing and the final divider settings.
module tb_clk_div_ctrl;

    localparam int WIDTH         = 5;
    localparam int MIN_RATIO     = 2;
    localparam int SETTLE_CYCLES = 4;
    localparam int TIMEOUT       = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_ratio;
    logic             cfg_enable;
    logic             cfg_err;
    logic             div_clk_in;
    logic [WIDTH-1:0] div_ratio_out;
    logic             div_en_out;
    logic             busy;
    logic             locked;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the divider configuration as seen from outside.
    int m_ratio;
    int m_en;

    always #5 clk = ~clk;

    clk_div_ctrl #(
        .WIDTH         (WIDTH),
        .MIN_RATIO     (MIN_RATIO),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_ratio     (cfg_ratio),
        .cfg_enable    (cfg_enable),
        .cfg_err       (cfg_err),
        .div_clk_in    (div_clk_in),
        .div_ratio_out (div_ratio_out),
        .div_en_out    (div_en_out),
        .busy          (busy),
        .locked        (locked)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        cfg_valid  = 1'b0;
        cfg_ratio  = '0;
        cfg_enable = 1'b0;
        div_clk_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(cfg_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_en", 32'(div_en_out), 0);
        check("rst_ratio", 32'(div_ratio_out), MIN_RATIO);
        check("rst_locked", 32'(locked), 0);
        check("rst_err", 32'(cfg_err), 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(cfg_ready), 1);
        m_ratio = MIN_RATIO;
        m_en    = 0;
        $display("reset applied");
    endtask

    // Issue one request. div_clk_in stays high for w cycles after acceptance, then falls.
    task automatic send_req(input int ratio, input int en, input int w);
        int n, exp_busy, exp_first;
        int busy_cnt, low_cnt, first_low, lock_busy, rdy_busy, viol, err_cnt;
        bit is_err, is_same, done;
        logic [WIDTH-1:0] prev_ratio;
        logic             prev_en;

        is_err  = (en == 1) && (ratio < MIN_RATIO);
        is_same = (ratio == m_ratio) && (en == m_en);
        n       = (w + 1 < TIMEOUT) ? (w + 1) : TIMEOUT;

        check("ready_before", 32'(cfg_ready), 1);
        cfg_valid  = 1'b1;
        cfg_ratio  = ratio[WIDTH-1:0];
        cfg_enable = en[0];
        div_clk_in = 1'b1;
        prev_ratio = div_ratio_out;
        prev_en    = div_en_out;
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;

        if (is_err || is_same) begin
            if (is_err) check("err_pulse", 32'(cfg_err), 1);
            else        check("same_no_err", 32'(cfg_err), 0);
            check("nochg_busy", 32'(busy), 0);
            check("nochg_ready", 32'(cfg_ready), 1);
            check("nochg_ratio", 32'(div_ratio_out), m_ratio);
            check("nochg_en", 32'(div_en_out), m_en);
            check("nochg_locked", 32'(locked), m_en);
            @(negedge clk);
            check("err_clear", 32'(cfg_err), 0);
            $display("req ratio=%0d en=%0d %s", ratio, en, is_err ? "rejected" : "unchanged");
            return;
        end

        if (m_en == 1) begin
            exp_busy  = n + 2 + ((en == 1) ? SETTLE_CYCLES : 0);
            exp_first = n + 2;
        end else begin
            exp_busy  = 1 + ((en == 1) ? SETTLE_CYCLES : 0);
            exp_first = 1;
        end

        busy_cnt = 0; low_cnt = 0; first_low = 0; lock_busy = 0;
        rdy_busy = 0; viol = 0; err_cnt = 0; done = 1'b0;
        for (int k = 1; k <= 400 && !done; k++) begin
            if (k > 1) @(negedge clk);
            if ((div_ratio_out != prev_ratio) && prev_en) viol++;
            if (cfg_err) err_cnt++;
            if (!busy) begin
                done = 1'b1;
            end else begin
                busy_cnt++;
                if (!div_en_out) begin
                    low_cnt++;
                    if (first_low == 0) first_low = k;
                end
                if (locked) lock_busy++;
                if (cfg_ready) rdy_busy++;
            end
            prev_ratio = div_ratio_out;
            prev_en    = div_en_out;
            if (k <= w)          div_clk_in = 1'b1;
            else if (k == w + 1) div_clk_in = 1'b0;
            else                 div_clk_in = 1'($urandom_range(0, 1));
        end

        check("busy_bound", 32'(done), 1);
        check("busy_cycles", busy_cnt, exp_busy);
        check("gate_first_low", first_low, exp_first);
        check("en_low_cycles", low_cnt, 1);
        check("locked_while_busy", lock_busy, 0);
        check("ready_while_busy", rdy_busy, 0);
        check("ratio_while_enabled", viol, 0);
        check("spurious_err", err_cnt, 0);
        check("final_ratio", 32'(div_ratio_out), ratio);
        check("final_en", 32'(div_en_out), en);
        check("final_locked", 32'(locked), en);
        check("final_ready", 32'(cfg_ready), 1);

        $display("req ratio=%0d en=%0d w=%0d from en=%0d busy=%0d", ratio, en, w, m_en, busy_cnt);
        m_ratio = ratio;
        m_en    = en;
    endtask

    // Enable from the disabled state, then hit reset while settling.
    task automatic reset_in_settle(input int ratio);
        cfg_valid  = 1'b1;
        cfg_ratio  = ratio[WIDTH-1:0];
        cfg_enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        check("rs_settling_busy", 32'(busy), 1);
        check("rs_settling_en", 32'(div_en_out), 1);
        reset = 1'b1;
        @(negedge clk);
        check("rs_busy", 32'(busy), 0);
        check("rs_en", 32'(div_en_out), 0);
        check("rs_ratio", 32'(div_ratio_out), MIN_RATIO);
        check("rs_locked", 32'(locked), 0);
        check("rs_ready_in_reset", 32'(cfg_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        check("rs_ready_after", 32'(cfg_ready), 1);
        m_ratio = MIN_RATIO;
        m_en    = 0;
        $display("reset during settle, ratio=%0d", ratio);
    endtask

    initial begin
        int r, e, w, sel;
        apply_reset();

        send_req(4, 1, 0);
        send_req(6, 1, 3);
        send_req(1, 1, 0);
        send_req(9, 1, 200);
        send_req(4, 1, 1);
        send_req(4, 0, 2);
        send_req(0, 0, 0);
        reset_in_settle(7);

        for (int i = 0; i < 80; i++) begin
            r   = int'($urandom_range(0, (1 << WIDTH) - 1));
            e   = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                r = m_ratio;
                e = m_en;
            end else if (sel == 1) begin
                r = int'($urandom_range(0, MIN_RATIO - 1));
                e = 1;
            end
            if (sel == 2) w = int'($urandom_range(TIMEOUT - 2, TIMEOUT + 20));
            else          w = int'($urandom_range(0, 12));
            send_req(r, e, w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
